// File: rtl/md_range_triggerer.sv
// Per-instrument price/size window trigger with sticky fire flags, one slot per instrument.
// Optional AGGRESSOR_ONLY_EN restricts matches to buy/sell aggressor updates.

module md_range_slot (
   input  logic         clk,
   input  logic         rst,
   input  logic         rst_trigger,
   input  logic [31:0]  security_id_trigger,
   input  logic [127:0] price_trigger,
   input  logic [63:0]  size_trigger,
   input  logic [31:0]  security_id,
   input  logic [63:0]  price,
   input  logic [31:0]  size,
   input  logic [1:0]   aggressor_side,
   input  logic         valid,
   output logic         fire
);
   typedef enum logic {ARMED = 1'b0, FIRED = 1'b1} state_t;

   state_t state, state_nxt;
   logic   side_ok;
   logic   id_hit, price_hit, size_hit, match;

`ifdef AGGRESSOR_ONLY_EN
   assign side_ok = (aggressor_side == 2'd1) || (aggressor_side == 2'd2);
`else
   logic unused_side;
   assign unused_side = ^aggressor_side;
   assign side_ok     = 1'b1;
`endif

   // An inverted window (lo > hi) can never satisfy both bounds, so it needs no special case.
   assign id_hit    = security_id == security_id_trigger;
   assign price_hit = ($signed(price) >= $signed(price_trigger[63:0])) &&
                      ($signed(price) <= $signed(price_trigger[127:64]));
   assign size_hit  = (size >= size_trigger[31:0]) && (size <= size_trigger[63:32]);
   assign match     = valid && side_ok && id_hit && price_hit && size_hit;

   always_ff @(posedge clk) begin
      if (!rst) state <= ARMED;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!rst_trigger)                   state_nxt = ARMED;
      else if (state == ARMED && match)   state_nxt = FIRED;
   end

   assign fire = (state == FIRED);
endmodule

module md_range_triggerer #(
   parameter int MAX_INSTRUMENTS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [MAX_INSTRUMENTS-1:0] rst_trigger,
   input  logic [31:0]                security_id_triggers [MAX_INSTRUMENTS],
   input  logic [127:0]               price_triggers       [MAX_INSTRUMENTS],
   input  logic [63:0]                size_triggers        [MAX_INSTRUMENTS],
   input  logic [31:0]                security_id,
   input  logic [63:0]                price,
   input  logic [31:0]                size,
   input  logic [1:0]                 aggressor_side,
   input  logic                       valid,
   output logic [MAX_INSTRUMENTS-1:0] fires
);
   for (genvar i = 0; i < MAX_INSTRUMENTS; i++) begin : g_slot
      md_range_slot u_slot (
         .clk                 (clk),
         .rst                 (rst),
         .rst_trigger         (rst_trigger[i]),
         .security_id_trigger (security_id_triggers[i]),
         .price_trigger       (price_triggers[i]),
         .size_trigger        (size_triggers[i]),
         .security_id         (security_id),
         .price               (price),
         .size                (size),
         .aggressor_side      (aggressor_side),
         .valid               (valid),
         .fire                (fires[i])
      );
   end
endmodule

// File: tb/tb_md_range_triggerer.sv
// Directed table-driven bench for md_range_triggerer with two slots.
module tb_md_range_triggerer;
   localparam int N = 2;
   localparam logic [63:0] P0 = 64'd453600000000000;
   localparam logic [63:0] P1 = 64'd453650000000000;
   localparam logic [63:0] H  = 64'd453620000000000;
   localparam logic [63:0] RL = 64'd428620000000000;
   localparam logic [63:0] RH = 64'd478620000000000;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   rst_trigger;
   logic [31:0]    security_id_triggers [N];
   logic [127:0]   price_triggers       [N];
   logic [63:0]    size_triggers        [N];
   logic [31:0]    security_id;
   logic [63:0]    price;
   logic [31:0]    size;
   logic [1:0]     aggressor_side;
   logic           valid;
   logic [N-1:0]   fires;

   int checks   = 0;
   int failures = 0;

   md_range_triggerer #(.MAX_INSTRUMENTS(N)) dut (
      .clk(clk), .rst(rst), .rst_trigger(rst_trigger),
      .security_id_triggers(security_id_triggers), .price_triggers(price_triggers),
      .size_triggers(size_triggers), .security_id(security_id), .price(price),
      .size(size), .aggressor_side(aggressor_side), .valid(valid), .fires(fires)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rt;
      logic [63:0] plo, phi;
      logic [31:0] id;
      logic [63:0] pr;
      logic [31:0] sz;
      logic [1:0]  side;
      logic        vld;
      logic [1:0]  exp;
   } vec_t;

   function automatic vec_t mk(logic [1:0] rt, logic [63:0] plo, logic [63:0] phi,
                               logic [31:0] id, logic [63:0] pr, logic [31:0] sz,
                               logic [1:0] side, logic vld, logic [1:0] exp);
      vec_t v;
      v.rt = rt; v.plo = plo; v.phi = phi; v.id = id; v.pr = pr; v.sz = sz;
      v.side = side; v.vld = vld; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] exp);
      checks++;
      if (fires !== exp) begin
         failures++;
         $display("FAIL %s fires=%b expected=%b", name, fires, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] id, input logic [63:0] pr, input logic [31:0] sz,
                      input logic [1:0] side, input logic vld);
      security_id = id; price = pr; size = sz; aggressor_side = side; valid = vld;
   endtask

   vec_t tbl [27];
   logic [1:0] side0_exp, side3_exp;

   initial begin
`ifdef AGGRESSOR_ONLY_EN
      side0_exp = 2'b00; side3_exp = 2'b00;
`else
      side0_exp = 2'b01; side3_exp = 2'b01;
`endif
      //            rt     plo  phi  id        price   size side vld exp
      tbl[0]  = mk(2'b11, P0, P1, 32'd3446, H,      1, 1, 1, 2'b00);
      tbl[1]  = mk(2'b11, P0, P1, 32'd3445, P0 - 1, 1, 1, 1, 2'b00);
      tbl[2]  = mk(2'b11, P0, P1, 32'd3445, P1 + 1, 1, 1, 1, 2'b00);
      tbl[3]  = mk(2'b11, P0, P1, 32'd3445, H,      2, 1, 1, 2'b00);
      tbl[4]  = mk(2'b11, P0, P1, 32'd3445, H,      0, 1, 1, 2'b00);
      tbl[5]  = mk(2'b11, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[6]  = mk(2'b11, P0, P1, 32'd3445, H,      1, 1, 1, 2'b01);
      tbl[7]  = mk(2'b11, P0, P1, 32'd3446, H,      1, 1, 1, 2'b01);
      tbl[8]  = mk(2'b11, P0, P1, 32'd3445, H,      1, 1, 1, 2'b01);
      tbl[9]  = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[10] = mk(2'b11, P0, P1, 32'd3445, P0,     1, 1, 1, 2'b01);
      tbl[11] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 1, 2'b00);
      tbl[12] = mk(2'b11, P0, P1, 32'd3445, P1,     1, 1, 1, 2'b01);
      tbl[13] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[14] = mk(2'b11, RL, RH, 32'd3445, RH,     1, 1, 1, 2'b01);
      tbl[15] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[16] = mk(2'b11, P1, P0, 32'd3445, H,      1, 1, 1, 2'b00);
      tbl[17] = mk(2'b11, H,  H,  32'd3445, H + 1,  1, 1, 1, 2'b00);
      tbl[18] = mk(2'b11, H,  H,  32'd3445, H,      1, 1, 1, 2'b01);
      tbl[19] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[20] = mk(2'b11, P0, P1, 32'd3445, H,      1, 0, 1, side0_exp);
      tbl[21] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[22] = mk(2'b11, P0, P1, 32'd3445, H,      1, 3, 1, side3_exp);
      tbl[23] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[24] = mk(2'b11, P0, P1, 32'd3445, H,      1, 2, 1, 2'b01);
      tbl[25] = mk(2'b10, P0, P1, 32'd3445, H,      1, 1, 0, 2'b00);
      tbl[26] = mk(2'b11, P0, P1, 32'd3445, H,      1, 1, 1, 2'b01);

      // slot 1: inverted price window so it stays quiet during the single-slot table
      security_id_triggers[0] = 32'd3445;
      price_triggers[0]       = {P1, P0};
      size_triggers[0]        = {32'd1, 32'd1};
      security_id_triggers[1] = 32'd3445;
      price_triggers[1]       = {64'd0, 64'd1};
      size_triggers[1]        = {32'hFFFF_FFFF, 32'd0};
      rst_trigger = 2'b11;
      upd(32'd3445, H, 1, 1, 1);
      rst = 1'b0;
      step();
      chk("reset_with_match", 2'b00);
      upd(32'd0, 64'd0, 0, 0, 0);
      step();
      chk("reset_hold", 2'b00);
      rst = 1'b1;
      step();
      chk("post_reset_idle", 2'b00);

      for (int i = 0; i < 27; i++) begin
         rst_trigger       = tbl[i].rt;
         price_triggers[0] = {tbl[i].phi, tbl[i].plo};
         upd(tbl[i].id, tbl[i].pr, tbl[i].sz, tbl[i].side, tbl[i].vld);
         step();
         chk($sformatf("vec%0d", i), tbl[i].exp);
      end

      // reset mid-operation: fired slot clears and a match under reset is dropped
      price_triggers[0] = {P1, P0};
      rst_trigger = 2'b11;
      upd(32'd3445, H, 1, 1, 1);
      step();
      chk("mid_fire", 2'b01);
      rst = 1'b0;
      step();
      chk("mid_reset_clear", 2'b00);
      step();
      chk("mid_reset_match_dropped", 2'b00);
      rst = 1'b1;
      upd(32'd3445, H, 1, 1, 0);
      step();
      chk("mid_reset_release", 2'b00);

      // multi-slot: overlapping windows on the same id
      price_triggers[1] = {H + 64'd1000000000000, H - 64'd1000000000000};
      size_triggers[1]  = {32'd10, 32'd0};
      upd(32'd3445, H, 1, 1, 1);
      step();
      chk("multi_both", 2'b11);
      rst_trigger = 2'b01;
      upd(32'd3445, H, 1, 1, 0);
      step();
      chk("multi_rearm_slot1", 2'b01);
      rst_trigger = 2'b11;
      upd(32'd3445, H, 5, 1, 1);
      step();
      chk("multi_slot1_only_size", 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/md_range_triggerer.md
# md_range_triggerer

Per-instrument price/size range trigger for parsed market-data updates. It sits downstream of the CME market-data parser. Each parsed update (security id, price, size, aggressor side, valid) is compared against up to MAX_INSTRUMENTS programmed windows. When an update falls inside a window, the block raises a sticky per-instrument fire flag. The flag stays set until the controller re-arms that instrument.

## Interface
Parameters:
- MAX_INSTRUMENTS, default 1: number of independent trigger slots (1..64).

Ports (clock and reset first):
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- rst_trigger  in  [MAX_INSTRUMENTS-1:0]  per-slot re-arm, active-low; while low, the slot's fire flag is cleared and the slot cannot fire.
- security_id_triggers  in  [31:0] x MAX_INSTRUMENTS (unpacked array)  security id that each slot matches.
- price_triggers  in  [127:0] x MAX_INSTRUMENTS  [127:64] = price_hi, [63:0] = price_lo; Price9 signed int64.
- size_triggers  in  [63:0] x MAX_INSTRUMENTS  [63:32] = size_hi, [31:0] = size_lo; unsigned.
- security_id  in  32  security id of the update.
- price  in  64  price of the update, signed.
- size  in  32  size of the update, unsigned.
- aggressor_side  in  2  side of the update: 0 = none, 1 = buy, 2 = sell, 3 = reserved.
- valid  in  1  single-cycle qualifier for the update fields.
- fires  out  [MAX_INSTRUMENTS-1:0]  sticky per-slot fire flags, registered.

## Operation
- Each slot i evaluates a combinational match term. match_i = valid AND all of the following:
  - security_id == security_id_triggers[i];
  - price_lo_i <= price <= price_hi_i, signed comparison, inclusive;
  - size_lo_i <= size <= size_hi_i, unsigned comparison, inclusive.
- Trigger inputs are sampled live in the cycle of the update. There is no internal copy of the trigger inputs.
- Per-slot state is a single flag: ARMED (fires[i] = 0) or FIRED (fires[i] = 1).
- Transitions:
  - ARMED -> FIRED when match_i is true and rst_trigger[i] = 1.
  - FIRED stays FIRED, ignoring further matches, until rst_trigger[i] = 0.
  - Any state -> ARMED when rst_trigger[i] = 0.
- Priority: rst = 0 first, then rst_trigger[i] = 0, then match. A match in a cycle where rst_trigger[i] = 0 is dropped.
- Degenerate windows:
  - If lo > hi in either dimension, the slot never fires.
  - If lo == hi, the window is an exact-value match.
- Several slots may match and fire in the same cycle. Slots are fully independent.
- Updates with valid = 0 are ignored regardless of field contents.

## Timing
- Reset: while rst = 0 at a rising edge, fires <= 0 for all slots.
- Latency: an update presented with valid = 1 at edge N produces fires[i] = 1 after edge N, visible in cycle N+1.
- fires[i] stays high until the first edge at which rst_trigger[i] = 0. It reads 0 from the following cycle.
- A match in the cycle after re-arm (rst_trigger[i] back at 1) can fire again.
- No backpressure; the block accepts one update per cycle.

## Configuration
- Macro AGGRESSOR_ONLY_EN.
- Defined: match_i additionally requires aggressor_side == 1 or aggressor_side == 2. Updates with side 0 or 3 never fire.
- Not defined: aggressor_side is ignored for matching.

## Test plan
- Basic hit:
  - Setup: slot 0 = id 3445, price [453600000000000, 453650000000000], size [1, 1].
  - Stimulus: update id 3445, price 453620000000000, size 1, valid.
  - Response: fires[0] = 1 one cycle later, and it stays 1 across further updates.
- Misses:
  - Same slot programmed as above.
  - Each of these produces fires[0] = 0: id 3446; price 453599999999999; price 453650000000001; size 2; valid = 0.
  - Boundary prices 453600000000000 and 453650000000000 each fire.
- Re-arm:
  - After a fire, drive rst_trigger[0] = 0 for one cycle -> fires[0] = 0.
  - Reprogram the window to price ±25000000000000 around the hit, present a matching update -> fires again.
  - A match in the same cycle as rst_trigger[0] = 0 -> no fire.
- Reset mid-operation:
  - Set fires[0] = 1, then drive rst = 0 for one cycle -> fires = 0.
  - Any matching update while rst = 0 -> no fire.
- Multi-slot (MAX_INSTRUMENTS = 2, both slots programmed for id 3445 with overlapping windows):
  - One matching update -> fires = 2'b11.
  - Re-arming slot 1 only -> 2'b01.
- Side filter with AGGRESSOR_ONLY_EN defined:
  - Matching update with side 0 -> no fire.
  - Same update with side 2 -> fire.
  - With the macro undefined, side 0 fires.
